// File: rtl/midi_preset_writer_if.sv
// Flash master bus used by the preset writer.
//   spi_adr_o  24  flash byte address
//   spi_dat_o  32  word to program
//   spi_we_o    1  write cycle
//   spi_stb_o   1  bus cycle request
//   spi_ack_i   1  cycle completed
//   spi_rty_i   1  flash busy, retry later
// master = preset writer side, slave = flash controller side.
interface midi_preset_writer_if;
  logic [23:0] spi_adr_o;
  logic [31:0] spi_dat_o;
  logic        spi_we_o;
  logic        spi_stb_o;
  logic        spi_ack_i;
  logic        spi_rty_i;

  modport master (
    output spi_adr_o, spi_dat_o, spi_we_o, spi_stb_o,
    input  spi_ack_i, spi_rty_i
  );

  modport slave (
    input  spi_adr_o, spi_dat_o, spi_we_o, spi_stb_o,
    output spi_ack_i, spi_rty_i
  );
endinterface

// File: rtl/midi_preset_writer.sv
// Preset write-back engine. Captures per-button MIDI presets into shadow
// registers, waits for a quiet period with no saves, then programs every dirty
// slot into flash at BASE_ADDR + (slot-1)*4, lowest slot first.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   save_stb   1-cycle pulse: capture save_word into save_slot
//   save_slot  slot 1..BUTTONS_CNT; 0 or out-of-range values are ignored
//   save_word  {status, data1, data2, bits_cnt}, status in [31:24]
//   flush_en   flash port is free for this block
//   spi        flash master bus (midi_preset_writer_if.master)
//   dirty      bit n-1 set = slot n holds data not yet in flash
//   busy       engine is not idle
//   err        sticky: a word ran out of retries; cleared by the next save
module midi_preset_writer #(
  parameter int          BUTTONS_CNT = 4,
  parameter logic [23:0] BASE_ADDR   = 24'h1ffd80,
  parameter int          QUIET_CNT   = 1_000_000,
  parameter int          RETRY_GAP   = 256,
  parameter int          MAX_RETRIES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    save_stb,
  input  logic [2:0]              save_slot,
  input  logic [31:0]             save_word,
  input  logic                    flush_en,
  midi_preset_writer_if.master    spi,
  output logic [BUTTONS_CNT-1:0]  dirty,
  output logic                    busy,
  output logic                    err
);

  // One timer serves both the quiet window and the retry gap.
  localparam int TIMER_MAX = (QUIET_CNT > RETRY_GAP) ? QUIET_CNT : RETRY_GAP;
  localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int RW        = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TW-1:0] QUIET_LAST = TW'(QUIET_CNT - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(RETRY_GAP - 1);
  localparam logic [RW-1:0] RTY_LAST   = RW'(MAX_RETRIES - 1);
  localparam logic [3:0]    MAX_SLOT   = 4'(BUTTONS_CNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIET,
    S_SCAN,
    S_WRITE,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retries_q, retries_d;
  logic [2:0]      cur_idx_q, cur_idx_d;
  logic [23:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            we_q, we_d;
  logic            stb_q, stb_d;
  logic            resaved_q, resaved_d;
  logic            err_q, err_d;
  logic            clear_dirty;

  logic [31:0]            shadow [BUTTONS_CNT];
  logic [BUTTONS_CNT-1:0] dirty_q;

  logic       save_valid;
  logic [2:0] save_idx;
  logic       save_hits_cur;
  logic       pick_found;
  logic [2:0] pick_idx;
  logic [31:0] pick_word;

  assign save_valid    = save_stb && (save_slot != 3'd0) && ({1'b0, save_slot} <= MAX_SLOT);
  assign save_idx      = save_slot - 3'd1;
  assign save_hits_cur = save_valid && (save_idx == cur_idx_q);

  // Lowest-numbered dirty slot wins: scan downward so the last hit is lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    pick_word  = 32'd0;
    for (int i = BUTTONS_CNT - 1; i >= 0; i--) begin
      if (dirty_q[i]) begin
        pick_found = 1'b1;
        pick_idx   = 3'(i);
        pick_word  = shadow[i];
      end
    end
  end

  // NOTE: the shadow words are a handful of flip-flops, so they are cleared on
  // reset like any other state; a RAM-backed store would be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUTTONS_CNT; i++) shadow[i] <= 32'd0;
      dirty_q <= '0;
    end else begin
      for (int i = 0; i < BUTTONS_CNT; i++) begin
        if (save_valid && (save_idx == 3'(i))) begin
          shadow[i]  <= save_word;
          dirty_q[i] <= 1'b1;
        end else if (clear_dirty && (cur_idx_q == 3'(i))) begin
          dirty_q[i] <= 1'b0;
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      retries_q <= '0;
      cur_idx_q <= 3'd0;
      adr_q     <= 24'd0;
      dat_q     <= 32'd0;
      we_q      <= 1'b0;
      stb_q     <= 1'b0;
      resaved_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      cur_idx_q <= cur_idx_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      stb_q     <= stb_d;
      resaved_q <= resaved_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retries_d   = retries_q;
    cur_idx_d   = cur_idx_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    stb_d       = stb_q;
    resaved_d   = resaved_q;
    err_d       = err_q;
    clear_dirty = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        // A failed slot stays dirty but waits for a fresh save before retrying.
        if ((dirty_q != '0) && !err_q) state_d = S_QUIET;
      end

      S_QUIET: begin
        if (save_valid) begin
          timer_d = '0;
        end else if (timer_q == QUIET_LAST) begin
          timer_d = '0;
          state_d = S_SCAN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_SCAN: begin
        if (!pick_found) begin
          state_d = S_IDLE;
        end else if (flush_en) begin
          adr_d     = BASE_ADDR + {19'd0, pick_idx, 2'b00};
          dat_d     = pick_word;
          we_d      = 1'b1;
          stb_d     = 1'b1;
          cur_idx_d = pick_idx;
          // The retry budget carries across a gap only for the same slot.
          if (pick_idx != cur_idx_q) retries_d = '0;
          // A save landing on the picked slot this cycle is newer than dat_d.
          resaved_d = save_valid && (save_idx == pick_idx);
          state_d   = S_WRITE;
        end
      end

      S_WRITE: begin
        if (save_hits_cur) resaved_d = 1'b1;
        if (spi.spi_ack_i) begin
          stb_d       = 1'b0;
          we_d        = 1'b0;
          retries_d   = '0;
          clear_dirty = !(resaved_q || save_hits_cur);
          state_d     = S_SCAN;
        end else if (spi.spi_rty_i) begin
          stb_d = 1'b0;
          we_d  = 1'b0;
          if (retries_q == RTY_LAST) begin
            err_d     = 1'b1;
            retries_d = '0;
            state_d   = S_IDLE;
          end else begin
            retries_d = retries_q + 1'b1;
            timer_d   = '0;
            state_d   = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = S_SCAN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Any accepted save re-arms the engine after a give-up.
    if (save_valid) err_d = 1'b0;
  end

  assign spi.spi_adr_o = adr_q;
  assign spi.spi_dat_o = dat_q;
  assign spi.spi_we_o  = we_q;
  assign spi.spi_stb_o = stb_q;
  assign dirty         = dirty_q;
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_midi_preset_writer.sv
// Self-checking bench for midi_preset_writer with short timer parameters.
// A flash responder process answers strobes with configurable delay/retry
// behaviour; a slot/word model predicts the acknowledged writes.
module tb_midi_preset_writer;
  localparam int          BUTTONS_CNT = 4;
  localparam logic [23:0] BASE_ADDR   = 24'h1ffd80;
  localparam int          QUIET_CNT   = 20;
  localparam int          RETRY_GAP   = 6;
  localparam int          MAX_RETRIES = 4;

  typedef struct {
    logic [23:0] adr;
    logic [31:0] dat;
    logic        we;
  } wr_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   save_stb = 1'b0;
  logic [2:0]             save_slot = 3'd0;
  logic [31:0]            save_word = 32'd0;
  logic                   flush_en = 1'b1;
  logic [BUTTONS_CNT-1:0] dirty;
  logic                   busy;
  logic                   err;

  midi_preset_writer_if spi();

  midi_preset_writer #(
    .BUTTONS_CNT(BUTTONS_CNT),
    .BASE_ADDR  (BASE_ADDR),
    .QUIET_CNT  (QUIET_CNT),
    .RETRY_GAP  (RETRY_GAP),
    .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .save_stb (save_stb),
    .save_slot(save_slot),
    .save_word(save_word),
    .flush_en (flush_en),
    .spi      (spi),
    .dirty    (dirty),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder controls (written by the main sequence only).
  bit respond_en    = 1'b1;
  bit rty_forever   = 1'b0;
  int rty_limit     = 0;
  int ack_delay_max = 0;
  // Responder observations (written by the responder only).
  int  rty_given  = 0;
  int  stb_cnt    = 0;
  int  low_cnt    = 0;
  int  stable_bad = 0;
  int  low_runs[$];
  wr_t ack_q[$];
  int  ack_base = 0;

  // Behavioural model: what each slot holds and whether flash is behind.
  logic [31:0] m_shadow [1:BUTTONS_CNT];
  bit          m_dirty  [1:BUTTONS_CNT];
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUTTONS_CNT-1:0] model_dirty();
    logic [BUTTONS_CNT-1:0] v = '0;
    for (int s = 1; s <= BUTTONS_CNT; s++) v[s-1] = m_dirty[s];
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 1; s <= BUTTONS_CNT; s++) begin
      m_shadow[s] = 32'd0;
      m_dirty[s]  = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Save lands on the posedge inside this task; returns 1 ns after it.
  task automatic do_save(input logic [2:0] slot, input logic [31:0] word);
    @(negedge clk);
    save_stb  = 1'b1;
    save_slot = slot;
    save_word = word;
    @(posedge clk);
    #1;
    save_stb = 1'b0;
    if (slot >= 1 && slot <= BUTTONS_CNT) begin
      m_shadow[slot] = word;
      m_dirty[slot]  = 1'b1;
      m_err          = 1'b0;
    end
  endtask

  task automatic wait_stb(input string tag, input int budget);
    int n = 0;
    while (!spi.spi_stb_o && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_stb_seen"}, spi.spi_stb_o, 1'b1);
  endtask

  // Expected writes: every dirty slot, ascending, with its latest word.
  task automatic run_flush(input string tag);
    wr_t exp_q[$];
    int  n = 0;
    for (int s = 1; s <= BUTTONS_CNT; s++) begin
      if (m_dirty[s]) begin
        exp_q.push_back('{adr: BASE_ADDR + 24'((s - 1) * 4), dat: m_shadow[s], we: 1'b1});
        m_dirty[s] = 1'b0;
      end
    end
    while (!((ack_q.size() - ack_base) >= exp_q.size() && !busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_done"}, n < 3000, 1'b1);
    check({tag, "_nwrites"}, ack_q.size() - ack_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && (ack_base + i) < ack_q.size(); i++) begin
      check($sformatf("%s_adr%0d", tag, i), ack_q[ack_base+i].adr, exp_q[i].adr);
      check($sformatf("%s_dat%0d", tag, i), ack_q[ack_base+i].dat, exp_q[i].dat);
      check($sformatf("%s_we%0d",  tag, i), ack_q[ack_base+i].we,  exp_q[i].we);
    end
    check({tag, "_dirty"}, dirty, model_dirty());
    check({tag, "_err"}, err, m_err);
    check({tag, "_busy"}, busy, 1'b0);
    ack_base = ack_q.size();
  endtask

  // Flash responder: logs strobes, verifies bus stability, answers ack/rty.
  initial begin
    bit  in_cycle = 1'b0;
    int  wait_cnt = 0;
    wr_t cur_wr;
    spi.spi_ack_i = 1'b0;
    spi.spi_rty_i = 1'b0;
    forever begin
      @(negedge clk);
      spi.spi_ack_i = 1'b0;
      spi.spi_rty_i = 1'b0;
      if (!spi.spi_stb_o) begin
        in_cycle = 1'b0;
        low_cnt++;
      end else begin
        if (!in_cycle) begin
          in_cycle = 1'b1;
          cur_wr   = '{adr: spi.spi_adr_o, dat: spi.spi_dat_o, we: spi.spi_we_o};
          stb_cnt++;
          low_runs.push_back(low_cnt);
          low_cnt  = 0;
          wait_cnt = int'($urandom_range(0, ack_delay_max));
        end else if (spi.spi_adr_o !== cur_wr.adr || spi.spi_dat_o !== cur_wr.dat ||
                     spi.spi_we_o !== cur_wr.we) begin
          stable_bad++;
        end
        if (respond_en) begin
          if (wait_cnt > 0) begin
            wait_cnt--;
          end else if (rty_forever || rty_given < rty_limit) begin
            spi.spi_rty_i = 1'b1;
            rty_given++;
          end else begin
            spi.spi_ack_i = 1'b1;
            ack_q.push_back(cur_wr);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int stb_mark;
    logic [31:0] w;

    model_reset();

    // Reset state.
    wait_cycles(3);
    check("rst_stb",   spi.spi_stb_o, 1'b0);
    check("rst_we",    spi.spi_we_o,  1'b0);
    check("rst_adr",   spi.spi_adr_o, 24'd0);
    check("rst_dat",   spi.spi_dat_o, 32'd0);
    check("rst_dirty", dirty, '0);
    check("rst_busy",  busy,  1'b0);
    check("rst_err",   err,   1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(2);

    // Single save: latency and bus contents.
    do_save(3'd2, 32'hB02E7F1E);
    check("t1_dirty_next", dirty, model_dirty());
    n = 0;
    while (!spi.spi_stb_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t1_latency", n, QUIET_CNT + 2);
    check("t1_adr", spi.spi_adr_o, 24'h1ffd84);
    check("t1_dat", spi.spi_dat_o, 32'hB02E7F1E);
    check("t1_we",  spi.spi_we_o,  1'b1);
    run_flush("t1");

    // Two slots in one quiet window: ascending order, two strobes.
    stb_mark = stb_cnt;
    do_save(3'd3, $urandom);
    wait_cycles(2);
    do_save(3'd1, $urandom);
    run_flush("t2");
    check("t2_strobes", stb_cnt - stb_mark, 2);

    // Two retries then ack.
    stb_mark  = stb_cnt;
    rty_limit = rty_given + 2;
    do_save(3'd4, $urandom);
    run_flush("t3");
    check("t3_strobes", stb_cnt - stb_mark, 3);
    check("t3_gap1", low_runs[low_runs.size()-2], RETRY_GAP + 1);
    check("t3_gap2", low_runs[low_runs.size()-1], RETRY_GAP + 1);

    // Retry on every cycle: give up after MAX_RETRIES strobes.
    stb_mark    = stb_cnt;
    rty_forever = 1'b1;
    do_save(3'd1, 32'h1234_5678);
    n = 0;
    while (!((stb_cnt - stb_mark) >= MAX_RETRIES && !busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    m_err = 1'b1;
    check("t4_done",    n < 3000, 1'b1);
    check("t4_strobes", stb_cnt - stb_mark, MAX_RETRIES);
    check("t4_err",     err,   m_err);
    check("t4_dirty",   dirty, model_dirty());
    check("t4_busy",    busy,  1'b0);
    wait_cycles(3 * QUIET_CNT);
    check("t4_no_auto_retry", stb_cnt - stb_mark, MAX_RETRIES);
    rty_forever = 1'b0;
    rty_limit   = rty_given;
    do_save(3'd2, $urandom);
    check("t4_err_cleared", err, m_err);
    run_flush("t4");

    // Save to the slot being written: old word goes out, slot stays dirty.
    stb_mark   = stb_cnt;
    respond_en = 1'b0;
    do_save(3'd1, 32'hA5A5_0001);
    wait_stb("t5", 200);
    do_save(3'd1, 32'hC042_0000);
    check("t5_dat_held", spi.spi_dat_o, 32'hA5A5_0001);
    check("t5_dirty_mid", dirty, model_dirty());
    respond_en = 1'b1;
    n = 0;
    while (!((ack_q.size() - ack_base) >= 2 && !busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_done",    n < 3000, 1'b1);
    check("t5_strobes", stb_cnt - stb_mark, 2);
    if (ack_q.size() - ack_base >= 2) begin
      check("t5_first_dat",  ack_q[ack_base].dat,   32'hA5A5_0001);
      check("t5_second_dat", ack_q[ack_base+1].dat, 32'hC042_0000);
    end
    m_dirty[1] = 1'b0;
    check("t5_dirty", dirty, model_dirty());
    ack_base = ack_q.size();

    // Port not available: engine holds in its scan and waits.
    stb_mark = stb_cnt;
    flush_en = 1'b0;
    do_save(3'd3, $urandom);
    wait_cycles(QUIET_CNT + 30);
    check("t6_no_stb", stb_cnt - stb_mark, 0);
    check("t6_busy",   busy, 1'b1);
    flush_en = 1'b1;
    run_flush("t6");

    // Reset in the middle of a write.
    respond_en = 1'b0;
    do_save(3'd2, $urandom);
    wait_stb("t7", 200);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("t7_stb_drop", spi.spi_stb_o, 1'b0);
    check("t7_dirty",    dirty, model_dirty());
    check("t7_err",      err,   m_err);
    check("t7_busy",     busy,  1'b0);
    @(negedge clk);
    rst = 1'b1;
    stb_mark = stb_cnt;
    wait_cycles(QUIET_CNT + 30);
    check("t7_no_stb", stb_cnt - stb_mark, 0);
    respond_en = 1'b1;

    // Randomised bursts: random slots (some invalid), words, delays, retries.
    for (int it = 0; it < 8; it++) begin
      int nsaves;
      ack_delay_max = int'($urandom_range(0, 3));
      rty_limit     = rty_given + int'($urandom_range(0, 2));
      nsaves        = int'($urandom_range(1, 5));
      for (int k = 0; k < nsaves; k++) begin
        w = $urandom;
        do_save(3'($urandom_range(0, 7)), w);
        wait_cycles(int'($urandom_range(0, 2)));
      end
      run_flush($sformatf("rnd%0d", it));
      rty_limit = rty_given;
    end

    check("bus_stable", stable_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
